reset_sequencer: RTL



---
 rtl/reset_seq_pkg.sv | 28 ++
 rtl/reset_seq_timer.sv | 28 ++
 rtl/reset_sequencer.sv | 120 ++++++++++++
 3 files changed

// File: rtl/reset_seq_pkg.sv
// Shared types and defaults for the reset sequencer.
// Default build leaves the DONE-state ack monitor (RESET_SEQ_ACK_MONITOR_EN) disabled.
package reset_seq_pkg;

  typedef enum logic [1:0] {
    ST_DELAY    = 2'd0,
    ST_WAIT_ACK = 2'd1,
    ST_DONE     = 2'd2,
    ST_FAULT    = 2'd3
  } seq_state_t;

  localparam int FAULT_IDX_W = 3;
  localparam int MAX_STAGES  = 8;

  // 50 MHz defaults: 1 ms settle per stage, 100 ms ack window.
  localparam int DEF_NUM_STAGES  = 4;
  localparam int DEF_STAGE_DELAY = 50000;
  localparam int DEF_ACK_TIMEOUT = 5000000;
  localparam int DEF_CNT_W       = 32;

  function automatic logic [FAULT_IDX_W-1:0] lowest_zero(input logic [MAX_STAGES-1:0] v);
    lowest_zero = '0;
    for (int i = MAX_STAGES - 1; i >= 0; i--) begin
      if (!v[i]) lowest_zero = FAULT_IDX_W'(i);
    end
  endfunction

endpackage

// File: rtl/reset_seq_timer.sv
// Up-counter shared by the settle delay and the ack timeout; tc is high for the
// single enabled cycle in which the count equals the supplied terminal value.
module reset_seq_timer
  import reset_seq_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] term,
  output logic             tc
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + CNT_W'(1);
    end
  end

  assign tc = en && (count == term);

endmodule

// File: rtl/reset_sequencer.sv
// Ordered, acknowledged release of NUM_STAGES active-low reset domains.
// Optional: define RESET_SEQ_ACK_MONITOR_EN to fault when an ack drops after DONE.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int NUM_STAGES  = DEF_NUM_STAGES,
  parameter int STAGE_DELAY = DEF_STAGE_DELAY,
  parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic                   OSC_50,
  input  logic                   RESET_N,
  input  logic                   FORCE_RST,
  input  logic [NUM_STAGES-1:0]  STAGE_ACK,
  output logic [NUM_STAGES-1:0]  RST_N_OUT,
  output logic                   SEQ_DONE,
  output logic                   SEQ_FAULT,
  output logic [FAULT_IDX_W-1:0] FAULT_STAGE,
  output seq_state_t             dbg_state
);

  localparam logic [CNT_W-1:0]       DELAY_TC = CNT_W'(STAGE_DELAY - 1);
  localparam logic [CNT_W-1:0]       ACK_TC   = CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [FAULT_IDX_W-1:0] LAST_IDX = FAULT_IDX_W'(NUM_STAGES - 1);

  // Handshake: STAGE_ACK[i] is a level "stage i is up" indication. It is only
  // looked at while waiting on stage i (first look is one cycle after release);
  // a high level there is accepted on that edge, even on the timeout edge.
  seq_state_t                state;
  logic [FAULT_IDX_W-1:0]    idx;
  logic [MAX_STAGES-1:0]     ack_ext;
  logic [NUM_STAGES-1:0]     stage_sel;
  logic                      ack_now;
  logic                      tmr_clr;
  logic                      tmr_en;
  logic [CNT_W-1:0]          tmr_term;
  logic                      tmr_tc;

  always_comb begin
    ack_ext   = '1;
    stage_sel = '0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      ack_ext[i]   = STAGE_ACK[i];
      stage_sel[i] = (idx == FAULT_IDX_W'(i));
    end
  end

  assign ack_now  = ack_ext[idx];
  assign tmr_en   = (state == ST_DELAY) || (state == ST_WAIT_ACK);
  assign tmr_term = (state == ST_DELAY) ? DELAY_TC : ACK_TC;
  assign tmr_clr  = FORCE_RST
                 || ((state == ST_DELAY) && tmr_tc)
                 || ((state == ST_WAIT_ACK) && ack_now);

  reset_seq_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk   (OSC_50),
    .rst_n (RESET_N),
    .clr   (tmr_clr),
    .en    (tmr_en),
    .term  (tmr_term),
    .tc    (tmr_tc)
  );

  always_ff @(posedge OSC_50) begin
    if (!RESET_N || FORCE_RST) begin
      state       <= ST_DELAY;
      idx         <= '0;
      RST_N_OUT   <= '0;
      SEQ_DONE    <= 1'b0;
      SEQ_FAULT   <= 1'b0;
      FAULT_STAGE <= '0;
    end else begin
      case (state)
        ST_DELAY: begin
          if (tmr_tc) begin
            RST_N_OUT <= RST_N_OUT | stage_sel;
            state     <= ST_WAIT_ACK;
          end
        end
        ST_WAIT_ACK: begin
          if (ack_now) begin
            if (idx == LAST_IDX) begin
              SEQ_DONE <= 1'b1;
              state    <= ST_DONE;
            end else begin
              idx   <= idx + FAULT_IDX_W'(1);
              state <= ST_DELAY;
            end
          end else if (tmr_tc) begin
            RST_N_OUT   <= '0;
            SEQ_FAULT   <= 1'b1;
            FAULT_STAGE <= idx;
            state       <= ST_FAULT;
          end
        end
        ST_DONE: begin
`ifdef RESET_SEQ_ACK_MONITOR_EN
          if (ack_ext != '1) begin
            RST_N_OUT   <= '0;
            SEQ_DONE    <= 1'b0;
            SEQ_FAULT   <= 1'b1;
            FAULT_STAGE <= lowest_zero(ack_ext);
            state       <= ST_FAULT;
          end
`else
          state <= ST_DONE;
`endif
        end
        default: begin
          state <= ST_FAULT;
        end
      endcase
    end
  end

  assign dbg_state = state;

endmodule
